// File: rtl/mbox_arbiter_pkg.sv
// ============================================================================
// Module  : mbox_arb_pkg
// Brief   : Shared types and constants for the mailbox write-port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mbox_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    // req_len_i encodes bytes-minus-one
    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_3B = 2'd2;
    localparam logic [1:0] LEN_4B = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mbox_arbiter_if.sv
// ============================================================================
// Module  : mbox_arbiter_if
// Brief   : Requester-side and mailbox-side signals of the mailbox arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface mbox_arbiter_if
    import mbox_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]        req_i;
    logic [NREQ*WORD_W-1:0] req_dat_i;
    logic [NREQ*2-1:0]      req_len_i;
    logic [NREQ-1:0]        gnt_o;
    logic                   busy_o;
    logic [ID_W-1:0]        cur_id_o;
    logic                   mbox_wr_o;
    logic [BYTE_W-1:0]      mbox_do_o;
    logic                   mbox_full_i;

    modport slave (
        input  req_i, req_dat_i, req_len_i, mbox_full_i,
        output gnt_o, busy_o, cur_id_o, mbox_wr_o, mbox_do_o
    );

    modport master (
        output req_i, req_dat_i, req_len_i, mbox_full_i,
        input  gnt_o, busy_o, cur_id_o, mbox_wr_o, mbox_do_o
    );
endinterface

`default_nettype wire

// File: rtl/mbox_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; first request after i_last.
//           MBOX_ARB_PRIO0_EN: requester 0 wins outright, others rotate.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [ID_W-1:0] i_last,
    output logic                 o_valid,
    output logic [ID_W-1:0]      o_id,
    output logic [NREQ-1:0]      o_onehot
);

    logic [NREQ-1:0] w_req;
    logic [ID_W:0]   w_k;

    always_comb begin
        w_req    = i_req;
        w_k      = '0;
        o_valid  = 1'b0;
        o_id     = '0;
        o_onehot = '0;
`ifdef MBOX_ARB_PRIO0_EN
        w_req[0] = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            // candidate = (last + 1 + i) mod NREQ; one subtraction suffices
            w_k = {1'b0, i_last} + (ID_W+1)'(i + 1);
            if (w_k >= (ID_W+1)'(NREQ)) begin
                w_k = w_k - (ID_W+1)'(NREQ);
            end
            if (!o_valid && w_req[w_k[ID_W-1:0]]) begin
                o_valid = 1'b1;
                o_id    = w_k[ID_W-1:0];
            end
        end
`ifdef MBOX_ARB_PRIO0_EN
        if (i_req[0]) begin
            o_valid = 1'b1;
            o_id    = '0;
        end
`endif
        if (o_valid) begin
            o_onehot[o_id] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mbox_arbiter.sv
// ============================================================================
// Module  : mbox_arbiter
// Brief   : Round-robin arbiter serializing 32-bit requester words LSB-first
//           into the byte-wide mailbox. Option macro: MBOX_ARB_PRIO0_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mbox_arbiter
    import mbox_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int WB_DW = 32
) (
    input  wire logic      wb_clk_i,
    input  wire logic      wb_rst_ni,
    mbox_arbiter_if.slave  bus
);

    state_t             r_state, w_state_nxt;
    logic [WB_DW-1:0]   r_buf,   w_buf_nxt;
    logic [1:0]         r_cnt,   w_cnt_nxt;
    logic [ID_W-1:0]    r_id,    w_id_nxt;
    logic [ID_W-1:0]    r_last,  w_last_nxt;
    logic [NREQ-1:0]    r_gnt,   w_gnt_nxt;

    logic               w_valid;
    logic [ID_W-1:0]    w_win;
    logic [NREQ-1:0]    w_onehot;
    logic               w_wr;

    rr_pick #(
        .NREQ     (NREQ),
        .ID_W     (ID_W)
    ) u_rr_pick (
        .i_req    (bus.req_i),
        .i_last   (r_last),
        .o_valid  (w_valid),
        .o_id     (w_win),
        .o_onehot (w_onehot)
    );

    // Decoded from the state register so reset kills the strobe at once
    assign w_wr = (r_state == ST_SEND) && !bus.mbox_full_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_cnt   <= LEN_1B;
            r_id    <= '0;
            r_last  <= ID_W'(NREQ - 1);
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_id_nxt    = r_id;
        w_last_nxt  = r_last;
        w_gnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_buf_nxt   = bus.req_dat_i[int'(w_win)*WB_DW +: WB_DW];
                    w_cnt_nxt   = bus.req_len_i[int'(w_win)*2 +: 2];
                    w_id_nxt    = w_win;
                    w_gnt_nxt   = w_onehot;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_wr) begin
                    w_buf_nxt = r_buf >> BYTE_W;
                    if (r_cnt == LEN_1B) begin
                        w_state_nxt = ST_IDLE;
`ifdef MBOX_ARB_PRIO0_EN
                        // Requester 0 bypasses the rotation, so it never moves the pointer
                        if (r_id != '0) begin
                            w_last_nxt = r_id;
                        end
`else
                        w_last_nxt = r_id;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
            end
        endcase
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.busy_o    = (r_state == ST_SEND);
    assign bus.cur_id_o  = r_id;
    assign bus.mbox_wr_o = w_wr;
    assign bus.mbox_do_o = r_buf[BYTE_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_mbox_arbiter.sv
// ============================================================================
// Module  : tb_mbox_arbiter
// Brief   : Directed self-checking bench for mbox_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mbox_arbiter;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_err;
    int n_busy;

    logic [7:0] q_byte[$];
    logic [3:0] q_gnt[$];

    mbox_arbiter_if #(.NREQ(4), .ID_W(2)) bus ();

    mbox_arbiter #(
        .NREQ      (4),
        .ID_W      (2),
        .WB_DW     (32)
    ) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Capture mailbox writes and grants midway between active edges
    always @(negedge clk) begin
        if (bus.mbox_wr_o) q_byte.push_back(bus.mbox_do_o);
        if (|bus.gnt_o)    q_gnt.push_back(bus.gnt_o);
        if (bus.busy_o)    n_busy = n_busy + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [31:0] d, input logic [1:0] l);
        bus.req_dat_i[32*k +: 32] = d;
        bus.req_len_i[2*k +: 2]   = l;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.req_i       = '0;
        bus.req_dat_i   = '0;
        bus.req_len_i   = '0;
        bus.mbox_full_i = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        q_byte.delete();
        q_gnt.delete();
        n_busy = 0;
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_count"}, q_byte.size(), exp.size());
        for (int i = 0; i < exp.size() && i < q_byte.size(); i++)
            chk(tag, {24'h0, q_byte[i]}, {24'h0, exp[i]});
    endtask

    task automatic chk_gnts(input string tag, input logic [3:0] exp[$]);
        chk({tag, "_count"}, q_gnt.size(), exp.size());
        for (int i = 0; i < exp.size() && i < q_gnt.size(); i++)
            chk(tag, {28'h0, q_gnt[i]}, {28'h0, exp[i]});
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        n_busy = 0;
        rst_n  = 1'b0;
        bus.req_i       = '0;
        bus.req_dat_i   = '0;
        bus.req_len_i   = '0;
        bus.mbox_full_i = 1'b0;
        #3;
        chk("rst_wr",   bus.mbox_wr_o, 1'b0);
        chk("rst_gnt",  bus.gnt_o,     4'h0);
        chk("rst_busy", bus.busy_o,    1'b0);
        chk("rst_id",   bus.cur_id_o,  2'd0);
        chk("rst_do",   bus.mbox_do_o, 8'h00);
        do_reset();

        // Single 4-byte word from requester 0, cycle by cycle
        set_word(0, 32'h44332211, 2'd3);
        bus.req_i = 4'b0001;
        tick(1);
        chk("t1_gnt",  bus.gnt_o,     4'b0001);
        chk("t1_busy", bus.busy_o,    1'b1);
        chk("t1_wr0",  bus.mbox_wr_o, 1'b1);
        chk("t1_b0",   bus.mbox_do_o, 8'h11);
        bus.req_i = 4'b0000;
        tick(1);
        chk("t1_gnt_low", bus.gnt_o,  4'b0000);
        chk("t1_b1",   bus.mbox_do_o, 8'h22);
        tick(1);
        chk("t1_b2",   bus.mbox_do_o, 8'h33);
        tick(1);
        chk("t1_b3",   bus.mbox_do_o, 8'h44);
        chk("t1_wr3",  bus.mbox_wr_o, 1'b1);
        tick(1);
        chk("t1_idle_busy", bus.busy_o,    1'b0);
        chk("t1_idle_wr",   bus.mbox_wr_o, 1'b0);
        chk("t1_id",        bus.cur_id_o,  2'd0);

        // All four requesting, single-byte words
        do_reset();
        for (int k = 0; k < 4; k++) set_word(k, 32'h000000A0 + 32'(k), 2'd0);
        bus.req_i = 4'b1111;
        tick(10);
        bus.req_i = 4'b0000;
        tick(3);
`ifdef MBOX_ARB_PRIO0_EN
        chk_bytes("t2_bytes", '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0});
        chk_gnts("t2_gnt", '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001});
`else
        chk_bytes("t2_bytes", '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0});
        chk_gnts("t2_gnt", '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001});
`endif
        chk("t2_busy_cycles", n_busy, 5);

        // Mailbox full for three cycles after the second byte
        do_reset();
        set_word(0, 32'hDEADBEEF, 2'd3);
        bus.req_i = 4'b0001;
        tick(1);
        bus.req_i = 4'b0000;
        tick(2);
        bus.mbox_full_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("t3_wr_full", bus.mbox_wr_o, 1'b0);
            chk("t3_do_hold", bus.mbox_do_o, 8'hAD);
            tick(1);
        end
        bus.mbox_full_i = 1'b0;
        tick(4);
        chk_bytes("t3_bytes", '{8'hEF, 8'hBE, 8'hAD, 8'hDE});
        chk("t3_busy", bus.busy_o, 1'b0);

        // Reset asserted during the second byte of a 4-byte word
        do_reset();
        set_word(0, 32'h04030201, 2'd3);
        bus.req_i = 4'b0001;
        tick(1);
        bus.req_i = 4'b0000;
        tick(1);
        chk("t4_do_b1", bus.mbox_do_o, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_wr_rst",   bus.mbox_wr_o, 1'b0);
        chk("t4_busy_rst", bus.busy_o,    1'b0);
        chk("t4_do_rst",   bus.mbox_do_o, 8'h00);
        #7;
        rst_n = 1'b1;
        tick(6);
        chk_bytes("t4_bytes", '{8'h01});
        chk("t4_wr_after", bus.mbox_wr_o, 1'b0);

        // Requester 2 withdraws during the deciding IDLE cycle
        do_reset();
        set_word(1, 32'h00005511, 2'd1);
        set_word(2, 32'h00000022, 2'd0);
        set_word(3, 32'h00000033, 2'd0);
        bus.req_i = 4'b1110;
        tick(1);
        bus.req_i = 4'b1100;
        tick(2);
        bus.req_i = 4'b1000;
        tick(1);
        chk("t5_gnt3", bus.gnt_o,    4'b1000);
        chk("t5_id3",  bus.cur_id_o, 2'd3);
        bus.req_i = 4'b0000;
        tick(3);
        chk_gnts("t5_gnt", '{4'b0010, 4'b1000});
        chk_bytes("t5_bytes", '{8'h11, 8'h55, 8'h33});

`ifdef MBOX_ARB_PRIO0_EN
        // Requester 0 dominates, then the rest rotate from the untouched pointer
        do_reset();
        for (int k = 0; k < 4; k++) set_word(k, 32'h000000B0 + 32'(k), 2'd0);
        bus.req_i = 4'b1111;
        tick(6);
        bus.req_i = 4'b1110;
        tick(8);
        bus.req_i = 4'b0000;
        tick(3);
        chk_gnts("t6_gnt", '{4'b0001, 4'b0001, 4'b0001,
                             4'b0010, 4'b0100, 4'b1000, 4'b0010});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
